// File: rtl/mem_req_arbiter_pkg.sv
// Shared widths, FSM encoding and client ids for the memory request arbiter.
// Also holds the round-robin pick helper used by mem_rr_arb2.
package mem_req_arbiter_pkg;

    // External memory port widths and line size in beats.
    localparam int MEM_ADDR_BITS   = 28;
    localparam int MEM_DATA_BITS   = 128;
    localparam int MEM_TAG_BITS    = 5;
    localparam int MEM_DATA_CYCLES = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2
    } arb_state_t;

    // Client id, which is also the MSB of the external tag.
    typedef enum logic {
        CL_IC = 1'b0,
        CL_DC = 1'b1
    } client_t;

    // Single requester wins; on a tie the client that did not win last
    // time wins. With no requester the previous owner is kept.
    function automatic client_t rr_pick(
        input logic    ic_v,
        input logic    dc_v,
        input client_t last
    );
        client_t pick;
        pick = last;
        unique case (1'b1)
            (ic_v & dc_v):  pick = (last == CL_IC) ? CL_DC : CL_IC;
            (ic_v & ~dc_v): pick = CL_IC;
            (~ic_v & dc_v): pick = CL_DC;
            default:        pick = last;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin picker between icache and dcache requests.
// Ports: clk, reset (sync, active-low), ic_valid/dc_valid requests,
// advance (grant consumed), grant_ic/grant_dc one-hot grant, grant_id.
module mem_rr_arb2
    import mem_req_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    ic_valid,
    input  logic    dc_valid,
    input  logic    advance,
    output logic    grant_ic,
    output logic    grant_dc,
    output client_t grant_id
);

    client_t last_grant;

    always_comb begin
        grant_id = rr_pick(ic_valid, dc_valid, last_grant);
        grant_ic = ic_valid & (grant_id == CL_IC);
        grant_dc = dc_valid & (grant_id == CL_DC);
    end

    // Starts at DC so the icache wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= CL_DC;
        end else if (advance) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges icache and dcache miss traffic onto one external memory port.
// Ports: ic_req_* / dc_req_* client requests, dc_req_data_* write beats,
// ic/dc_resp_valid + resp_tag/resp_data responses, mem_req_* / mem_resp_*
// external port. clk, reset (synchronous, active-low).
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_BITS   = MEM_ADDR_BITS,
    parameter int DATA_BITS   = MEM_DATA_BITS,
    parameter int TAG_BITS    = MEM_TAG_BITS,
    parameter int DATA_CYCLES = MEM_DATA_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic [TAG_BITS-2:0]    ic_req_tag,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic [TAG_BITS-2:0]    dc_req_tag,

    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,

    output logic                   ic_resp_valid,
    output logic                   dc_resp_valid,
    output logic [TAG_BITS-2:0]    resp_tag,
    output logic [DATA_BITS-1:0]   resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,

    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,

    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_CYCLES - 1);

    arb_state_t          state;
    logic [CNT_W-1:0]    beat_cnt;
    logic                req_rw;
    logic [ADDR_BITS-1:0] req_addr;
    logic [TAG_BITS-1:0] req_tag;

    logic    grant_ic;
    logic    grant_dc;
    client_t grant_id;
    logic    in_idle;
    logic    in_addr;
    logic    in_wdata;
    logic    ic_hs;
    logic    dc_hs;
    logic    beat_hs;

    // Every handshake strobe is masked while reset is held low so the
    // block looks idle immediately, not one cycle later.
    assign in_idle  = reset & (state == ST_IDLE);
    assign in_addr  = reset & (state == ST_ADDR);
    assign in_wdata = reset & (state == ST_WDATA);

    mem_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .advance  (ic_hs | dc_hs),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc),
        .grant_id (grant_id)
    );

    assign ic_req_ready = in_idle & grant_ic;
    assign dc_req_ready = in_idle & grant_dc;
    assign ic_hs        = ic_req_valid & ic_req_ready;
    assign dc_hs        = dc_req_valid & dc_req_ready;

    assign mem_req_valid = in_addr;
    assign mem_req_rw    = req_rw;
    assign mem_req_addr  = req_addr;
    assign mem_req_tag   = req_tag;

    // Write beats flow straight through; only the handshake is gated.
    assign mem_req_data_valid = in_wdata & dc_req_data_valid;
    assign dc_req_data_ready  = in_wdata & mem_req_data_ready;
    assign mem_req_data_bits  = dc_req_data_bits;
    assign mem_req_data_mask  = dc_req_data_mask;
    assign beat_hs = mem_req_data_valid & mem_req_data_ready;

    // Responses are steered by tag MSB, independent of the request FSM.
    assign ic_resp_valid = reset & mem_resp_valid
                         & ~mem_resp_tag[TAG_BITS-1];
    assign dc_resp_valid = reset & mem_resp_valid
                         & mem_resp_tag[TAG_BITS-1];
    assign resp_tag      = mem_resp_tag[TAG_BITS-2:0];
    assign resp_data     = mem_resp_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            req_rw   <= 1'b0;
            req_addr <= '0;
            req_tag  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // Readies are one-hot, so at most one handshake fires.
                    unique case (1'b1)
                        ic_hs: begin
                            req_rw   <= 1'b0;
                            req_addr <= ic_req_addr;
                            req_tag  <= {grant_id, ic_req_tag};
                            state    <= ST_ADDR;
                        end
                        dc_hs: begin
                            req_rw   <= dc_req_rw;
                            req_addr <= dc_req_addr;
                            req_tag  <= {grant_id, dc_req_tag};
                            state    <= ST_ADDR;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_ADDR: begin
                    if (mem_req_ready) begin
                        state <= req_rw ? ST_WDATA : ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (beat_hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter.
// Inputs change just after posedge; outputs are checked at negedge.
module tb_mem_req_arbiter;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;

    logic              clk;
    logic              reset;
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [AB-1:0]     ic_req_addr;
    logic [TB-2:0]     ic_req_tag;
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [AB-1:0]     dc_req_addr;
    logic [TB-2:0]     dc_req_tag;
    logic              dc_req_data_valid;
    logic              dc_req_data_ready;
    logic [DB-1:0]     dc_req_data_bits;
    logic [DB/8-1:0]   dc_req_data_mask;
    logic              ic_resp_valid;
    logic              dc_resp_valid;
    logic [TB-2:0]     resp_tag;
    logic [DB-1:0]     resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [AB-1:0]     mem_req_addr;
    logic [TB-1:0]     mem_req_tag;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready;
    logic [DB-1:0]     mem_req_data_bits;
    logic [DB/8-1:0]   mem_req_data_mask;
    logic              mem_resp_valid;
    logic [TB-1:0]     mem_resp_tag;
    logic [DB-1:0]     mem_resp_data;

    int checks = 0;
    int failures = 0;

    mem_req_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .ic_req_valid       (ic_req_valid),
        .ic_req_ready       (ic_req_ready),
        .ic_req_addr        (ic_req_addr),
        .ic_req_tag         (ic_req_tag),
        .dc_req_valid       (dc_req_valid),
        .dc_req_ready       (dc_req_ready),
        .dc_req_rw          (dc_req_rw),
        .dc_req_addr        (dc_req_addr),
        .dc_req_tag         (dc_req_tag),
        .dc_req_data_valid  (dc_req_data_valid),
        .dc_req_data_ready  (dc_req_data_ready),
        .dc_req_data_bits   (dc_req_data_bits),
        .dc_req_data_mask   (dc_req_data_mask),
        .ic_resp_valid      (ic_resp_valid),
        .dc_resp_valid      (dc_resp_valid),
        .resp_tag           (resp_tag),
        .resp_data          (resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [DB-1:0] obs,
                       input logic [DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] beat_pat(input int k);
        logic [7:0] b;
        b = 8'(8'h11 * (k + 1));
        return {16{b}};
    endfunction

    // Drives n beats with mem_req_data_ready high on odd cycles only.
    task automatic write_beats(input string tag, input int n);
        int beat;
        logic rdy;
        beat = 0;
        dc_req_data_valid = 1'b1;
        dc_req_data_mask  = '1;
        for (int c = 0; c < 20 && beat < n; c++) begin
            rdy = (c % 2) == 1;
            dc_req_data_bits   = beat_pat(beat);
            mem_req_data_ready = rdy;
            mid();
            chk({tag, "_dvalid"}, DB'(mem_req_data_valid), DB'(1));
            chk({tag, "_dready"}, DB'(dc_req_data_ready), DB'(rdy));
            chk({tag, "_bits"}, mem_req_data_bits, beat_pat(beat));
            chk({tag, "_mask"}, DB'(mem_req_data_mask), DB'(16'hFFFF));
            if (rdy) beat++;
            nxt();
        end
        chk({tag, "_nbeats"}, DB'(beat), DB'(n));
        // An extra beat after the line must not be accepted.
        dc_req_data_bits   = {16{8'h55}};
        mem_req_data_ready = 1'b1;
        mid();
        chk({tag, "_x5_ack"}, DB'(dc_req_data_ready), DB'(0));
        chk({tag, "_x5_fwd"}, DB'(mem_req_data_valid), DB'(0));
        dc_req_data_valid  = 1'b0;
        mem_req_data_ready = 1'b0;
        nxt();
    endtask

    initial begin
        reset = 1'b0;
        ic_req_valid = 1'b0;
        ic_req_addr = '0;
        ic_req_tag = '0;
        dc_req_valid = 1'b0;
        dc_req_rw = 1'b0;
        dc_req_addr = '0;
        dc_req_tag = '0;
        dc_req_data_valid = 1'b0;
        dc_req_data_bits = '0;
        dc_req_data_mask = '0;
        mem_req_ready = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag = '0;
        mem_resp_data = '0;
        nxt();
        nxt();

        // Held in reset: everything idle despite active inputs.
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        dc_req_data_valid = 1'b1;
        mem_req_data_ready = 1'b1;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 5'h10;
        mid();
        chk("rst_ic_rdy", DB'(ic_req_ready), DB'(0));
        chk("rst_dc_rdy", DB'(dc_req_ready), DB'(0));
        chk("rst_mreq_v", DB'(mem_req_valid), DB'(0));
        chk("rst_mdata_v", DB'(mem_req_data_valid), DB'(0));
        chk("rst_dc_drdy", DB'(dc_req_data_ready), DB'(0));
        chk("rst_dc_resp", DB'(dc_resp_valid), DB'(0));
        nxt();

        // Contention from reset: ic, dc, ic.
        reset = 1'b1;
        dc_req_data_valid = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        ic_req_addr = 28'h00000A0;
        ic_req_tag = 4'h1;
        dc_req_addr = 28'h00000B0;
        dc_req_tag = 4'h2;
        mid();
        chk("tie_ic_rdy", DB'(ic_req_ready), DB'(1));
        chk("tie_dc_rdy", DB'(dc_req_ready), DB'(0));
        nxt();
        mid();
        chk("c1_v", DB'(mem_req_valid), DB'(1));
        chk("c1_tag", DB'(mem_req_tag), DB'(5'h01));
        chk("c1_addr", DB'(mem_req_addr), DB'(28'h00000A0));
        chk("c1_ic_rdy", DB'(ic_req_ready), DB'(0));
        chk("c1_dc_rdy", DB'(dc_req_ready), DB'(0));
        nxt();
        mid();
        chk("c2_dc_rdy", DB'(dc_req_ready), DB'(1));
        chk("c2_ic_rdy", DB'(ic_req_ready), DB'(0));
        nxt();
        mid();
        chk("c2_tag", DB'(mem_req_tag), DB'(5'h12));
        chk("c2_addr", DB'(mem_req_addr), DB'(28'h00000B0));
        chk("c2_rw", DB'(mem_req_rw), DB'(0));
        nxt();
        mid();
        chk("c3_ic_rdy", DB'(ic_req_ready), DB'(1));
        chk("c3_dc_rdy", DB'(dc_req_ready), DB'(0));
        nxt();
        mid();
        chk("c3_tag", DB'(mem_req_tag), DB'(5'h01));
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        nxt();

        // Plain icache read and its response.
        ic_req_valid = 1'b1;
        ic_req_addr = 28'h0000100;
        ic_req_tag = 4'h3;
        mid();
        chk("r_ic_rdy", DB'(ic_req_ready), DB'(1));
        nxt();
        ic_req_valid = 1'b0;
        mid();
        chk("r_v", DB'(mem_req_valid), DB'(1));
        chk("r_tag", DB'(mem_req_tag), DB'(5'h03));
        chk("r_rw", DB'(mem_req_rw), DB'(0));
        chk("r_addr", DB'(mem_req_addr), DB'(28'h0000100));
        nxt();
        mid();
        chk("r_done", DB'(mem_req_valid), DB'(0));
        mem_resp_valid = 1'b1;
        mem_resp_tag = 5'h03;
        mem_resp_data = {4{32'hDEADBEEF}};
        #1;
        chk("r_ic_resp", DB'(ic_resp_valid), DB'(1));
        chk("r_dc_resp", DB'(dc_resp_valid), DB'(0));
        chk("r_resp_tag", DB'(resp_tag), DB'(4'h3));
        chk("r_resp_data", resp_data, {4{32'hDEADBEEF}});
        nxt();
        mem_resp_valid = 1'b0;

        // Backpressure: request held stable for 6 cycles.
        mem_req_ready = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr = 28'h0ABCDEF;
        ic_req_tag = 4'h7;
        nxt();
        dc_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("s_v", DB'(mem_req_valid), DB'(1));
            chk("s_addr", DB'(mem_req_addr), DB'(28'h0ABCDEF));
            chk("s_tag", DB'(mem_req_tag), DB'(5'h07));
            chk("s_ic_rdy", DB'(ic_req_ready), DB'(0));
            chk("s_dc_rdy", DB'(dc_req_ready), DB'(0));
            nxt();
        end
        mem_req_ready = 1'b1;
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        nxt();

        // dcache write with a response landing on the capture cycle.
        dc_req_valid = 1'b1;
        dc_req_rw = 1'b1;
        dc_req_addr = 28'h0000200;
        dc_req_tag = 4'h5;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 5'h12;
        mid();
        chk("w_dc_rdy", DB'(dc_req_ready), DB'(1));
        chk("w_dc_resp", DB'(dc_resp_valid), DB'(1));
        chk("w_ic_resp", DB'(ic_resp_valid), DB'(0));
        chk("w_resp_tag", DB'(resp_tag), DB'(4'h2));
        nxt();
        dc_req_valid = 1'b0;
        mem_resp_valid = 1'b0;
        dc_req_data_valid = 1'b1;
        mem_req_data_ready = 1'b1;
        mid();
        chk("w_v", DB'(mem_req_valid), DB'(1));
        chk("w_rw", DB'(mem_req_rw), DB'(1));
        chk("w_tag", DB'(mem_req_tag), DB'(5'h15));
        chk("w_addr", DB'(mem_req_addr), DB'(28'h0000200));
        chk("w_addr_nofwd", DB'(mem_req_data_valid), DB'(0));
        chk("w_addr_noack", DB'(dc_req_data_ready), DB'(0));
        nxt();
        write_beats("wd", 4);

        // Reset during the write-data phase after 2 beats.
        dc_req_valid = 1'b1;
        dc_req_addr = 28'h0000300;
        dc_req_tag = 4'h6;
        nxt();
        dc_req_valid = 1'b0;
        nxt();
        dc_req_data_valid = 1'b1;
        mem_req_data_ready = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
        ic_req_valid = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 5'h00;
        mid();
        chk("mr_mreq_v", DB'(mem_req_valid), DB'(0));
        chk("mr_mdata_v", DB'(mem_req_data_valid), DB'(0));
        chk("mr_dc_drdy", DB'(dc_req_data_ready), DB'(0));
        chk("mr_ic_rdy", DB'(ic_req_ready), DB'(0));
        chk("mr_dc_rdy", DB'(dc_req_ready), DB'(0));
        chk("mr_ic_resp", DB'(ic_resp_valid), DB'(0));
        nxt();
        reset = 1'b1;
        mem_resp_valid = 1'b0;
        ic_req_addr = 28'h0000400;
        ic_req_tag = 4'h2;
        dc_req_valid = 1'b1;
        dc_req_rw = 1'b0;
        dc_req_addr = 28'h0000500;
        dc_req_tag = 4'h1;
        mid();
        chk("pr_ic_rdy", DB'(ic_req_ready), DB'(1));
        chk("pr_dc_rdy", DB'(dc_req_ready), DB'(0));
        chk("pr_mdata_v", DB'(mem_req_data_valid), DB'(0));
        nxt();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        dc_req_data_valid = 1'b0;
        mem_req_data_ready = 1'b0;
        mid();
        chk("pr_v", DB'(mem_req_valid), DB'(1));
        chk("pr_tag", DB'(mem_req_tag), DB'(5'h02));
        chk("pr_rw", DB'(mem_req_rw), DB'(0));
        chk("pr_addr", DB'(mem_req_addr), DB'(28'h0000400));
        nxt();
        mid();
        chk("pr_done", DB'(mem_req_valid), DB'(0));
        nxt();

        // Full line write after reset: beat counter must start at 0.
        dc_req_valid = 1'b1;
        dc_req_rw = 1'b1;
        dc_req_addr = 28'h0000600;
        dc_req_tag = 4'h4;
        nxt();
        dc_req_valid = 1'b0;
        mid();
        chk("w2_tag", DB'(mem_req_tag), DB'(5'h14));
        chk("w2_rw", DB'(mem_req_rw), DB'(1));
        nxt();
        write_beats("wd2", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
